// File: rtl/mux_scan_serializer.sv
// -----------------------------------------------------------------------------
// mux_scan_serializer
//
// Sequencer for an external 8:1 multiplexer stage. A word is latched on an
// accepted start, driven onto the mux data inputs, and the 3-bit select is
// stepped through all eight positions. After HOLD cycles on each select value
// the mux output is sampled, emitted as a serial bit, and merged into a
// reconstructed word. After the eighth sample the reconstructed word is
// compared against the latched word, giving a loopback check of the mux.
//
// Parameters:
//   HOLD       cycles each select value is held before sampling (1..255)
//   MSB_FIRST  0: select order 0..7, 1: select order 7..0
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      scan request, sampled only while idle
//   data_in    word to scan, latched on the accepted start edge
//   mux_y      output of the external mux (combinational from mux_data/sel)
//   mux_data   latched word; bit i drives mux input Ii
//   sel        mux select
//   ser_bit    most recently sampled mux_y
//   ser_valid  one-cycle pulse, ser_bit is new this cycle
//   busy       high from the accepted start until the end of the done cycle
//   done       one-cycle pulse after the eighth sample
//   rx_word    reconstructed word; bit i = mux_y sampled with sel = i
//   mismatch   rx_word != mux_data, updated at the eighth sample
// -----------------------------------------------------------------------------
module mux_scan_serializer #(
    parameter int HOLD      = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       mux_y,
    output logic [7:0] mux_data,
    output logic [2:0] sel,
    output logic       ser_bit,
    output logic       ser_valid,
    output logic       busy,
    output logic       done,
    output logic [7:0] rx_word,
    output logic       mismatch
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } state_t;

    // Terminal hold count; HOLD=1 makes every scan edge a sample edge.
    localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
    localparam logic [2:0] SEL_FIRST = MSB_FIRST ? 3'd7 : 3'd0;

    state_t     state_reg;
    logic [7:0] mux_data_reg;
    logic [2:0] sel_reg;
    logic [7:0] hold_cnt_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] rx_word_reg;
    logic       ser_bit_reg;
    logic       ser_valid_reg;
    logic       busy_reg;
    logic       done_reg;
    logic       mismatch_reg;

    logic       sample_edge;
    logic [2:0] sel_next;
    logic [7:0] rx_word_next;

    assign sample_edge = (hold_cnt_reg == HOLD_LAST);
    assign sel_next    = MSB_FIRST ? (sel_reg - 3'd1) : (sel_reg + 3'd1);

    // Reconstructed word with the bit currently being sampled merged in.
    // Used both as the rx_word update and for the final comparison, so the
    // mismatch flag sees the eighth bit in the same edge it is captured.
    for (genvar gi = 0; gi < 8; gi++) begin : g_rx_merge
        assign rx_word_next[gi] = (sel_reg == 3'(gi)) ? mux_y : rx_word_reg[gi];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            mux_data_reg  <= 8'd0;
            sel_reg       <= 3'd0;
            hold_cnt_reg  <= 8'd0;
            bit_cnt_reg   <= 3'd0;
            rx_word_reg   <= 8'd0;
            ser_bit_reg   <= 1'b0;
            ser_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mismatch_reg  <= 1'b0;
        end else begin
            // Pulse outputs default low; they are raised only on the edges
            // that produce them.
            ser_valid_reg <= 1'b0;
            done_reg      <= 1'b0;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        mux_data_reg <= data_in;
                        sel_reg      <= SEL_FIRST;
                        hold_cnt_reg <= 8'd0;
                        bit_cnt_reg  <= 3'd0;
                        rx_word_reg  <= 8'd0;
                        mismatch_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_SCAN;
                    end
                end

                ST_SCAN: begin
                    if (sample_edge) begin
                        hold_cnt_reg  <= 8'd0;
                        ser_bit_reg   <= mux_y;
                        ser_valid_reg <= 1'b1;
                        rx_word_reg   <= rx_word_next;
                        if (bit_cnt_reg == 3'd7) begin
                            // Last sample: select stays on the final index.
                            mismatch_reg <= (rx_word_next != mux_data_reg);
                            done_reg     <= 1'b1;
                            state_reg    <= ST_DONE;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            sel_reg     <= sel_next;
                        end
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 8'd1;
                    end
                end

                ST_DONE: begin
                    // start is deliberately not looked at here; a new scan
                    // can only be accepted from the following idle cycle.
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mux_data  = mux_data_reg;
    assign sel       = sel_reg;
    assign ser_bit   = ser_bit_reg;
    assign ser_valid = ser_valid_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign rx_word   = rx_word_reg;
    assign mismatch  = mismatch_reg;

endmodule

// File: tb/tb_mux_scan_serializer.sv
// -----------------------------------------------------------------------------
// tb_mux_scan_serializer
//
// Three instances share one stimulus stream:
//   dut0: HOLD=1, LSB first   dut1: HOLD=1, MSB first   dut2: HOLD=3, LSB first
// Each instance drives its own mux model (with a shared stuck-at-0 mask).
// A cycle-position model predicts every output; directed scans add literal
// expectations that pin the model to hand-derived values.
// -----------------------------------------------------------------------------
module tb_mux_scan_serializer;

    localparam int NDUT = 3;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] data_in;
    logic [7:0] stuck;

    logic [7:0] mux_data_w  [NDUT];
    logic [2:0] sel_w       [NDUT];
    logic       mux_y_w     [NDUT];
    logic       ser_bit_w   [NDUT];
    logic       ser_valid_w [NDUT];
    logic       busy_w      [NDUT];
    logic       done_w      [NDUT];
    logic [7:0] rx_word_w   [NDUT];
    logic       mismatch_w  [NDUT];

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int H = (gi == 2) ? 3 : 1;
        localparam bit M = (gi == 1);
        mux_scan_serializer #(.HOLD(H), .MSB_FIRST(M)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start),
            .data_in  (data_in),
            .mux_y    (mux_y_w[gi]),
            .mux_data (mux_data_w[gi]),
            .sel      (sel_w[gi]),
            .ser_bit  (ser_bit_w[gi]),
            .ser_valid(ser_valid_w[gi]),
            .busy     (busy_w[gi]),
            .done     (done_w[gi]),
            .rx_word  (rx_word_w[gi]),
            .mismatch (mismatch_w[gi])
        );
        // External 8:1 mux with optional stuck-at-0 inputs.
        assign mux_y_w[gi] = mux_data_w[gi][sel_w[gi]] & ~stuck[sel_w[gi]];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input int j,
                       input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d: got %0h expected %0h at %0t", name, j, act, exp, $time);
        end
    endtask

    function automatic int hold_of(input int j);
        return (j == 2) ? 3 : 1;
    endfunction

    function automatic bit msb_of(input int j);
        return (j == 1);
    endfunction

    // ------------------------------------------------------------------
    // Reference model: tracks only "cycles since the accepted start" (t)
    // per instance and derives every output from that position.
    // t=1 is the cycle right after the accept edge; samples are taken so
    // that sample n is visible from t = n*H+1; done is at t = 8*H+1.
    // ------------------------------------------------------------------
    bit         m_act   [NDUT] = '{default: 1'b0};
    int         m_t     [NDUT] = '{default: 0};
    logic [7:0] m_word  [NDUT] = '{default: 8'd0};
    logic [7:0] m_rx    [NDUT] = '{default: 8'd0};
    logic       m_mis   [NDUT] = '{default: 1'b0};
    logic       m_sbit  [NDUT] = '{default: 1'b0};
    logic       m_valid [NDUT] = '{default: 1'b0};
    logic       m_done  [NDUT] = '{default: 1'b0};
    logic [2:0] m_sel   [NDUT] = '{default: 3'd0};

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int j = 0; j < NDUT; j++) begin
                if (!rst_n) begin
                    m_act[j] = 0; m_t[j] = 0; m_word[j] = 0; m_rx[j] = 0;
                    m_mis[j] = 0; m_sbit[j] = 0; m_valid[j] = 0; m_done[j] = 0;
                    m_sel[j] = 0;
                end else begin
                    int h, s, pos, idx;
                    h = hold_of(j);
                    if (!m_act[j]) begin
                        if (start) begin
                            m_act[j] = 1; m_t[j] = 1; m_word[j] = data_in;
                            m_rx[j] = 0; m_mis[j] = 0;
                        end
                    end else if (m_t[j] == 8 * h + 1) begin
                        m_act[j] = 0;
                    end else begin
                        m_t[j]++;
                    end
                    m_valid[j] = 0;
                    m_done[j]  = 0;
                    if (m_act[j]) begin
                        s = (m_t[j] - 1) / h;
                        if (s > 8) s = 8;
                        pos = (s > 7) ? 7 : s;
                        m_sel[j]  = 3'(msb_of(j) ? 7 - pos : pos);
                        m_done[j] = (m_t[j] == 8 * h + 1);
                        if (m_t[j] > 1 && ((m_t[j] - 1) % h) == 0) begin
                            idx = msb_of(j) ? 8 - s : s - 1;
                            m_sbit[j]     = m_word[j][idx] & ~stuck[idx];
                            m_rx[j][idx]  = m_sbit[j];
                            m_valid[j]    = 1;
                            if (s == 8) m_mis[j] = (m_rx[j] != m_word[j]);
                        end
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int j = 0; j < NDUT; j++) begin
                    chk("mux_data",  j, 32'(mux_data_w[j]),  32'(m_word[j]));
                    chk("sel",       j, 32'(sel_w[j]),       32'(m_sel[j]));
                    chk("ser_bit",   j, 32'(ser_bit_w[j]),   32'(m_sbit[j]));
                    chk("ser_valid", j, 32'(ser_valid_w[j]), 32'(m_valid[j]));
                    chk("busy",      j, 32'(busy_w[j]),      32'(m_act[j]));
                    chk("done",      j, 32'(done_w[j]),      32'(m_done[j]));
                    chk("rx_word",   j, 32'(rx_word_w[j]),   32'(m_rx[j]));
                    chk("mismatch",  j, 32'(mismatch_w[j]),  32'(m_mis[j]));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Directed scan helper: records observations for literal checks.
    // ------------------------------------------------------------------
    logic [7:0] seq0, seq1;
    int         done0_c, done2_c, busy2_n, valid2_n;
    logic       mis0_first;
    logic [2:0] sel1_first;

    task automatic do_scan(input logic [7:0] w);
        @(negedge clk);
        start = 1'b1;
        data_in = w;
        seq0 = 0; seq1 = 0; done0_c = 0; done2_c = 0; busy2_n = 0; valid2_n = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                data_in = 8'($urandom);
                mis0_first = mismatch_w[0];
                sel1_first = sel_w[1];
            end
            if (ser_valid_w[0]) seq0 = {seq0[6:0], ser_bit_w[0]};
            if (ser_valid_w[1]) seq1 = {seq1[6:0], ser_bit_w[1]};
            if (done_w[0] && done0_c == 0) done0_c = c;
            if (done_w[2] && done2_c == 0) done2_c = c;
            if (busy_w[2]) busy2_n++;
            if (ser_valid_w[2]) valid2_n++;
        end
        $display("scan word=%02h: rx0=%02h rx1=%02h rx2=%02h mis0=%0d seq0=%02h seq1=%02h done0@%0d done2@%0d",
                 w, rx_word_w[0], rx_word_w[1], rx_word_w[2], mismatch_w[0], seq0, seq1, done0_c, done2_c);
    endtask

    initial begin
        int nd;
        int gap_run, first_gap;
        bit prev_b, seen_b;

        rst_n = 1'b0;
        start = 1'b0;
        data_in = 8'd0;
        stuck = 8'd0;
        @(negedge clk);
        chk_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_sel", 0, 32'(sel_w[0]), 0);
        chk("reset_busy", 2, 32'(busy_w[2]), 0);
        chk("reset_mux_data", 1, 32'(mux_data_w[1]), 0);
        rst_n = 1'b1;

        // LSB-first, HOLD=1: bits 1,0,1,0,0,1,0,1; done 9 cycles after start.
        do_scan(8'hA5);
        chk("a5_seq", 0, 32'(seq0), 32'hA5);
        chk("a5_done_cycle", 0, done0_c, 9);
        chk("a5_rx", 0, 32'(rx_word_w[0]), 32'hA5);
        chk("a5_mismatch", 0, 32'(mismatch_w[0]), 0);

        // MSB-first: select 7..0, serial 0,0,0,0,0,0,0,1.
        do_scan(8'h01);
        chk("01_sel_first", 1, 32'(sel1_first), 7);
        chk("01_sel_last", 1, 32'(sel_w[1]), 0);
        chk("01_seq", 1, 32'(seq1), 32'h01);
        chk("01_seq_lsb", 0, 32'(seq0), 32'h80);
        chk("01_rx", 1, 32'(rx_word_w[1]), 32'h01);

        // HOLD=3: done and busy span 25 cycles, eight valid pulses.
        do_scan(8'h3C);
        chk("3c_done_cycle", 2, done2_c, 25);
        chk("3c_busy_len", 2, busy2_n, 25);
        chk("3c_valid_cnt", 2, valid2_n, 8);
        chk("3c_rx", 2, 32'(rx_word_w[2]), 32'h3C);

        // I4 stuck at 0 with an all-ones word.
        stuck = 8'h10;
        do_scan(8'hFF);
        chk("stuck_rx", 0, 32'(rx_word_w[0]), 32'hEF);
        chk("stuck_mismatch", 0, 32'(mismatch_w[0]), 1);
        chk("stuck_rx_hold3", 2, 32'(rx_word_w[2]), 32'hEF);
        repeat (5) @(negedge clk);
        chk("stuck_mismatch_held", 0, 32'(mismatch_w[0]), 1);
        stuck = 8'h00;
        do_scan(8'h00);
        chk("mismatch_cleared", 0, 32'(mis0_first), 0);

        // Reset in the middle of a scan.
        @(negedge clk);
        start = 1'b1;
        data_in = 8'hC3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_w[0] || done_w[1] || done_w[2]) nd++;
        end
        chk("rst_busy", 0, 32'(busy_w[0]), 0);
        chk("rst_rx", 2, 32'(rx_word_w[2]), 0);
        chk("rst_no_done", 0, nd, 0);
        rst_n = 1'b1;
        do_scan(8'h5A);
        chk("after_rst_rx", 0, 32'(rx_word_w[0]), 32'h5A);
        chk("after_rst_mis", 0, 32'(mismatch_w[0]), 0);
        chk("after_rst_rx_msb", 1, 32'(rx_word_w[1]), 32'h5A);

        // start held high: back-to-back scans with one idle cycle between.
        @(negedge clk);
        start = 1'b1;
        gap_run = 0; first_gap = -1; prev_b = 0; seen_b = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            data_in = 8'($urandom);
            if (!busy_w[0]) begin
                gap_run++;
            end else begin
                if (!prev_b && seen_b && first_gap < 0) first_gap = gap_run;
                gap_run = 0;
                seen_b = 1;
            end
            prev_b = busy_w[0];
        end
        chk("b2b_idle_gap", 0, first_gap, 1);
        start = 1'b0;
        repeat (30) @(negedge clk);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            data_in = 8'($urandom);
            if (!m_act[0] && !m_act[1] && !m_act[2] && $urandom_range(0, 15) == 0)
                stuck = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
            if ($urandom_range(0, 149) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (30) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
